// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, data, optional parity, stop.
// Drives load/shift strobes and the output mux select per baud tick.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  localparam int CNT_W = $clog2(DATA_WIDTH)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DATA_VALID,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic       BAUD_TICK,
  output logic       LOAD,
  output logic       BAUD_CLR,
  output logic       SER_SHIFT,
  output logic [1:0] MUX_SEL,
  output logic       PAR_ODD,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             par_en_q;
  logic             accept;
  logic             shift;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      par_en_q <= 1'b0;
      PAR_ODD  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      if (accept) begin
        par_en_q <= PAR_EN;
        PAR_ODD  <= PAR_TYP;
      end
    end
  end

  // Strobes are masked during reset so nothing leaks while RST is held
  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    accept  = 1'b0;
    shift   = 1'b0;
    unique case (state)
      IDLE: begin
        accept = DATA_VALID;
      end
      START: begin
        if (BAUD_TICK) state_n = DATA;
      end
      DATA: begin
        if (BAUD_TICK) begin
          shift = 1'b1;
          if (bit_cnt == LAST) begin
            cnt_n   = '0;
            state_n = par_en_q ? PARITY : STOP;
          end else begin
            cnt_n = bit_cnt + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (BAUD_TICK) state_n = STOP;
      end
      STOP: begin
        if (BAUD_TICK) begin
          if (DATA_VALID) accept = 1'b1;
          else state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    accept = accept & ~RST;
    shift  = shift & ~RST;
    if (accept) begin
      state_n = START;
      cnt_n   = '0;
    end
  end

  assign LOAD      = accept;
  assign BAUD_CLR  = accept;
  assign SER_SHIFT = shift;

  always_comb begin
    MUX_SEL = 2'b11;
    BUSY    = 1'b1;
    unique case (state)
      IDLE:    BUSY    = 1'b0;
      START:   MUX_SEL = 2'b00;
      DATA:    MUX_SEL = 2'b01;
      PARITY:  MUX_SEL = 2'b10;
      STOP:    MUX_SEL = 2'b11;
      default: BUSY    = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: reset, parity/no-parity frames,
// back-to-back accept, mid-frame noise and mid-frame reset.
module tb_uart_tx_ctrl;

  logic       CLK;
  logic       RST;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       BAUD_TICK;
  logic       LOAD;
  logic       BAUD_CLR;
  logic       SER_SHIFT;
  logic [1:0] MUX_SEL;
  logic       PAR_ODD;
  logic       BUSY;

  int errors = 0;
  int checks = 0;

  int         n_load;
  int         n_clr;
  int         n_shift;
  int         n_busy;
  int         n_tick;
  logic [1:0] seq [16];
  logic       last_load;
  logic [1:0] last_mux;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .BAUD_TICK  (BAUD_TICK),
    .LOAD       (LOAD),
    .BAUD_CLR   (BAUD_CLR),
    .SER_SHIFT  (SER_SHIFT),
    .MUX_SEL    (MUX_SEL),
    .PAR_ODD    (PAR_ODD),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear();
    n_load  = 0;
    n_clr   = 0;
    n_shift = 0;
    n_busy  = 0;
    n_tick  = 0;
  endtask

  // One clock cycle: apply inputs, sample, advance past the next edge
  task automatic drive(input logic dv, input logic pe,
                       input logic pt, input logic tk);
    DATA_VALID = dv;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    BAUD_TICK  = tk;
    #2;
    if (LOAD === 1'b1) n_load++;
    if (BAUD_CLR === 1'b1) n_clr++;
    if (SER_SHIFT === 1'b1) n_shift++;
    if (BUSY === 1'b1) n_busy++;
    if (tk && n_tick < 16) begin
      seq[n_tick] = MUX_SEL;
      n_tick++;
    end
    last_load = LOAD;
    last_mux  = MUX_SEL;
    @(posedge CLK);
    #1;
  endtask

  // Bit periods of four cycles each, tick on the fourth
  task automatic body(input logic pe, input logic noise,
                      input logic end_dv, input logic end_pe,
                      input logic end_pt);
    int np;
    np = 10 + int'(pe);
    for (int p = 0; p < np; p++) begin
      for (int c = 0; c < 3; c++) begin
        if (noise && p >= 1 && p <= 8)
          drive(1'(c % 2), 1'((c + 1) % 2), 1'(p % 2), 1'b0);
        else
          drive(1'b0, 1'b0, 1'b0, 1'b0);
      end
      if (p == np - 1)
        drive(end_dv, end_pe, end_pt, 1'b1);
      else if (noise && p >= 1 && p <= 8)
        drive(1'b1, 1'(p % 2), 1'((p + 1) % 2), 1'b1);
      else
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  function automatic logic [1:0] exp_mux(input int i, input logic pe);
    if (i == 0) return 2'b00;
    if (i <= 8) return 2'b01;
    if (pe && i == 9) return 2'b10;
    return 2'b11;
  endfunction

  task automatic check_frame(input string nm, input logic pe,
                             input int loads);
    chk({nm, ".load"}, n_load, loads);
    chk({nm, ".clr"}, n_clr, loads);
    chk({nm, ".shift"}, n_shift, 8);
    chk({nm, ".busy"}, n_busy, (10 + int'(pe)) * 4);
    chk({nm, ".ticks"}, n_tick, 10 + int'(pe));
    for (int i = 0; i < n_tick; i++)
      chk($sformatf("%s.mux%0d", nm, i), 32'(seq[i]), 32'(exp_mux(i, pe)));
  endtask

  task automatic check_idle(input string nm);
    chk({nm, ".idle_busy"}, BUSY, 0);
    chk({nm, ".idle_mux"}, MUX_SEL, 2'b11);
  endtask

  initial begin
    RST        = 1'b1;
    DATA_VALID = 1'b1;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b1;
    BAUD_TICK  = 1'b0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk($sformatf("rst%0d.mux", i), MUX_SEL, 2'b11);
      chk($sformatf("rst%0d.busy", i), BUSY, 0);
      chk($sformatf("rst%0d.load", i), LOAD, 0);
      @(posedge CLK);
      #1;
    end
    chk("rst.par_odd", PAR_ODD, 0);
    chk("rst.bit_cnt", 32'(dut.bit_cnt), 0);
    RST = 1'b0;

    clear();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    chk("par.latency", MUX_SEL, 2'b00);
    body(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("par", 1'b1, 1);
    chk("par.par_odd", PAR_ODD, 1);
    check_idle("par");

    clear();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check_idle("idle_tick");
    chk("idle_tick.load", n_load, 0);

    clear();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    body(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("nopar", 1'b0, 1);
    chk("nopar.par_odd", PAR_ODD, 0);
    check_idle("nopar");

    clear();
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    body(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_frame("b2b_a", 1'b0, 2);
    chk("b2b.tick_load", last_load, 1);
    chk("b2b.tick_mux", last_mux, 2'b11);
    chk("b2b.next_mux", MUX_SEL, 2'b00);
    chk("b2b.next_busy", BUSY, 1);
    clear();
    body(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("b2b_b", 1'b1, 0);
    chk("b2b_b.par_odd", PAR_ODD, 0);
    check_idle("b2b_b");

    clear();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    body(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_frame("noise", 1'b0, 1);
    chk("noise.par_odd", PAR_ODD, 0);
    check_idle("noise");

    clear();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 3; c++) drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("mid.bit_cnt", 32'(dut.bit_cnt), 2);
    chk("mid.mux", MUX_SEL, 2'b01);
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    chk("mid_rst.mux", MUX_SEL, 2'b11);
    chk("mid_rst.busy", BUSY, 0);
    chk("mid_rst.bit_cnt", 32'(dut.bit_cnt), 0);
    chk("mid_rst.par_odd", PAR_ODD, 0);

    clear();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    body(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_frame("after_rst", 1'b1, 1);
    chk("after_rst.par_odd", PAR_ODD, 1);
    check_idle("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmitter. Accepts a byte request, loads the parity calculator and serializer, then walks the output mux through start, data, optional parity and stop bits, one bit per baud tick. It sits between the host-side request interface and the TX datapath: parity calculator, serializer, baud generator and output mux.

Parameters:
DATA_WIDTH, 8, data bits per frame (range 5..9); sets bit counter range
CNT_W, $clog2(DATA_WIDTH), bit counter width (derived; not overridden)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
DATA_VALID  input  1  host request: a byte is present on the datapath input
PAR_EN  input  1  parity bit enable, sampled at accept
PAR_TYP  input  1  0 = even, 1 = odd, sampled at accept
BAUD_TICK  input  1  one-cycle pulse per bit period from the baud generator
LOAD  output  1  one-cycle pulse: parity calculator and serializer capture data
BAUD_CLR  output  1  one-cycle pulse, coincident with LOAD: restart baud generator phase
SER_SHIFT  output  1  one-cycle pulse: serializer advances to next data bit
MUX_SEL  output  2  00 start (0), 01 serializer bit, 10 parity, 11 stop/idle (1)
PAR_ODD  output  1  latched PAR_TYP; the output mux inverts the parity bit when 1
BUSY  output  1  high while a frame is in progress

Behaviour:
- Clocking and reset: single clock. RST is synchronous, active-high.
- Reset state: state=IDLE, bit_cnt=0, latched par_en=0, PAR_ODD=0, MUX_SEL=11, BUSY=0. LOAD, BAUD_CLR and SER_SHIFT are 0.
- Reset mid-frame aborts the frame at the next CLK edge. The line returns to idle (MUX_SEL=11) with no partial stop bit.
- FSM states: IDLE, START, DATA, PARITY, STOP. MUX_SEL and BUSY are Moore outputs decoded from the state register.
  - IDLE: MUX_SEL=11, BUSY=0.
  - All other states: BUSY=1, with MUX_SEL = 00 (START), 01 (DATA), 10 (PARITY), 11 (STOP).
- Accept condition: (state==IDLE, or state==STOP with BAUD_TICK) and DATA_VALID=1.
  - In the accept cycle, LOAD=1 and BAUD_CLR=1. These are combinational Mealy outputs, one cycle wide.
  - At the accept edge, PAR_EN and PAR_TYP are latched, bit_cnt is cleared, and the next state is START.
  - DATA_VALID is ignored in every other cycle; no queuing.
- START -> DATA on BAUD_TICK.
- DATA: SER_SHIFT=1 in each cycle where BAUD_TICK=1 (combinational), and bit_cnt increments.
  - On BAUD_TICK with bit_cnt==DATA_WIDTH-1: go to PARITY if latched par_en=1, else STOP, and clear bit_cnt.
  - This gives exactly DATA_WIDTH SER_SHIFT pulses per frame. The last pulse is harmless to the serializer.
- PARITY -> STOP on BAUD_TICK.
- STOP, on BAUD_TICK:
  - DATA_VALID=1: accept back-to-back, go directly to START with no idle gap.
  - Otherwise: go to IDLE.
- BAUD_TICK in IDLE is ignored.
- Parameter changes to PAR_EN/PAR_TYP mid-frame have no effect on the current frame.
- Frame length in bit periods: 1 + DATA_WIDTH + par_en + 1.
- Latency: MUX_SEL=00 appears one cycle after the accept cycle.
- PAR_ODD holds its value until the next accept or reset.
- bit_cnt never exceeds DATA_WIDTH-1; no wrap occurs within DATA.

Test Plan:
- Reset: hold RST=1 for 2 cycles with DATA_VALID=1 -> MUX_SEL=11, BUSY=0, LOAD=0 throughout; first accept only after RST falls.
- Parity frame: DATA_WIDTH=8, BAUD_TICK every 4 cycles, PAR_EN=1, PAR_TYP=1 -> exactly one LOAD/BAUD_CLR pulse; MUX_SEL sequence 00, 01 (x8 ticks), 10, 11; 8 SER_SHIFT pulses; PAR_ODD=1; BUSY high for 11 tick periods.
- No-parity frame: PAR_EN=0 -> MUX_SEL never 10; BUSY high for 10 tick periods; return to IDLE after the stop tick.
- Back-to-back: DATA_VALID held high across the STOP tick -> LOAD pulses in the same cycle as that tick; MUX_SEL goes 11 -> 00 with no idle cycle; the second frame uses the PAR_EN sampled at the second accept.
- Mid-frame noise: toggle DATA_VALID and PAR_EN during DATA -> no extra LOAD, and the frame length is unchanged.
- Reset mid-frame: assert RST during the third data bit -> next cycle MUX_SEL=11, BUSY=0, bit_cnt=0; a new request then produces a full, correct frame.
